// File: rtl/ipsmacge_pkg.sv
// rtl/ipsmacge_pkg.sv - shared speed codes, FSM states and helpers for the GE transmit interface
package ipsmacge_pkg;

    // up_mspd encodings
    typedef enum logic [1:0] {
        M10      = 2'b00,
        M100     = 2'b01,
        M1000    = 2'b10,
        MRESERVE = 2'b11
    } spd_e;

    // transmit FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FRAME = 2'b01,
        IFG   = 2'b10
    } state_e;

    // 10/100M move one byte as two nibbles over two cycles
    function automatic logic is_nibble(input spd_e spd);
        return (spd == M10) || (spd == M100);
    endfunction

endpackage

// File: rtl/ipsmacge_txenc.sv
// rtl/ipsmacge_txenc.sv - registered GMII/MII/RGMII pin encoder for one staged byte
//
// Ports:
//   clk, rst   : transmit clock, synchronous active-high reset
//   clr        : port disabled, drive idle pins on the next edge
//   gmii, spd  : latched interface mode and speed
//   nib_hi     : 1 selects dat[7:4] as the current nibble, 0 selects dat[3:0]
//   dat/en/er  : staged byte and its frame-enable / error flags
//   hdat/ldat  : rising / falling edge data banks (hdat is also the SDR data)
//   hctl/lctl  : rising / falling edge control
//   err        : GMII/MII TX_ER
module ipsmacge_txenc
    import ipsmacge_pkg::*;
#(
    parameter int DAT_DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              gmii,
    input  spd_e              spd,
    input  logic              nib_hi,
    input  logic [DAT_DW-1:0] dat,
    input  logic              en,
    input  logic              er,
    output logic [DAT_DW-1:0] hdat,
    output logic [DAT_DW-1:0] ldat,
    output logic              hctl,
    output logic              lctl,
    output logic              err
);

    localparam int NIB_W = DAT_DW / 2;

    logic [DAT_DW-1:0] hdat_d, hdat_q;
    logic [DAT_DW-1:0] ldat_d, ldat_q;
    logic              hctl_d, hctl_q;
    logic              lctl_d, lctl_q;
    logic              err_d,  err_q;

    logic [DAT_DW-1:0] nib_x;
    logic [DAT_DW-1:0] lo_x;
    logic [DAT_DW-1:0] hi_x;

    always_comb begin
        lo_x  = {{NIB_W{1'b0}}, dat[NIB_W-1:0]};
        hi_x  = {{NIB_W{1'b0}}, dat[DAT_DW-1:NIB_W]};
        nib_x = nib_hi ? hi_x : lo_x;

        hdat_d = '0;
        ldat_d = '0;
        hctl_d = 1'b0;
        lctl_d = 1'b0;
        err_d  = 1'b0;

        if (!clr && en) begin
            if (gmii) begin
                hctl_d = 1'b1;
                lctl_d = 1'b1;
                err_d  = er;
                if (spd == M1000) begin
                    hdat_d = dat;
                    ldat_d = dat;
                end else begin
                    hdat_d = nib_x;
                    ldat_d = nib_x;
                end
            end else begin
                // RGMII carries TX_ER on the falling edge as en^er
                hctl_d = 1'b1;
                lctl_d = ~er;
                if (spd == M1000) begin
                    hdat_d = lo_x;
                    ldat_d = hi_x;
                end else begin
                    hdat_d = nib_x;
                    ldat_d = nib_x;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdat_q <= '0;
            ldat_q <= '0;
            hctl_q <= 1'b0;
            lctl_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            hdat_q <= hdat_d;
            ldat_q <= ldat_d;
            hctl_q <= hctl_d;
            lctl_q <= lctl_d;
            err_q  <= err_d;
        end
    end

    assign hdat = hdat_q;
    assign ldat = ldat_q;
    assign hctl = hctl_q;
    assign lctl = lctl_q;
    assign err  = err_q;

endmodule

// File: rtl/ipsmacge_txintf.sv
// rtl/ipsmacge_txintf.sv - triple-speed GE transmit PHY interface with IFG enforcement
//
// Ports:
//   txclk, txrst          : transmit clock, synchronous active-high reset
//   igdat, igen, iger     : MAC byte and its frame-enable / error, taken when igrdy=1
//   igrdy                 : byte-take strobe to the MAC
//   txhdat/txldat         : rising / falling edge data banks
//   txhctl/txlctl         : rising / falling edge control
//   txerr                 : GMII/MII TX_ER
//   up_act, up_gmii, up_mspd : port enable, interface select, speed select
module ipsmacge_txintf
    import ipsmacge_pkg::*;
#(
    parameter int DAT_DW = 8,
    parameter int MSP_DW = 2,
    parameter int IFG_BT = 12,
    parameter int CNT_W  = 9
) (
    input  logic              txclk,
    input  logic              txrst,
    input  logic [DAT_DW-1:0] igdat,
    input  logic              igen,
    input  logic              iger,
    output logic              igrdy,
    output logic [DAT_DW-1:0] txhdat,
    output logic [DAT_DW-1:0] txldat,
    output logic              txhctl,
    output logic              txlctl,
    output logic              txerr,
    input  logic              up_act,
    input  logic              up_gmii,
    input  logic [MSP_DW-1:0] up_mspd
);

    localparam logic [CNT_W-1:0] IFG_GIG = CNT_W'(IFG_BT - 1);
    localparam logic [CNT_W-1:0] IFG_NIB = CNT_W'(2 * IFG_BT - 1);

    state_e            state_d, state_q;
    logic              phase_d, phase_q;
    logic [CNT_W-1:0]  cnt_d,   cnt_q;
    logic              gmii_d,  gmii_q;
    spd_e              spd_d,   spd_q;
    logic              igrdy_d, igrdy_q;
    logic [DAT_DW-1:0] stg_dat_d, stg_dat_q;
    logic              stg_en_d,  stg_en_q;
    logic              stg_er_d,  stg_er_q;

    logic act_ok;
    logic take;
    logic xmit;

    always_comb begin
        act_ok = up_act && (spd_q != MRESERVE);
        take   = igrdy_q && act_ok;
        xmit   = take && igen && (state_q != IFG);
    end

    // state register
    always_ff @(posedge txclk) begin
        if (txrst) begin
            state_q   <= IDLE;
            phase_q   <= 1'b0;
            cnt_q     <= '0;
            gmii_q    <= 1'b0;
            spd_q     <= M10;
            igrdy_q   <= 1'b0;
            stg_dat_q <= '0;
            stg_en_q  <= 1'b0;
            stg_er_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            gmii_q    <= gmii_d;
            spd_q     <= spd_d;
            igrdy_q   <= igrdy_d;
            stg_dat_q <= stg_dat_d;
            stg_en_q  <= stg_en_d;
            stg_er_q  <= stg_er_d;
        end
    end

    // next-state: FSM, IFG counter, mode latch, byte phase
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        // mode only follows the inputs between frames
        gmii_d = (state_q == IDLE) ? up_gmii : gmii_q;
        spd_d  = (state_q == IDLE) ? spd_e'(up_mspd) : spd_q;

        if (!act_ok) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take && igen) begin
                        state_d = FRAME;
                    end
                end
                FRAME: begin
                    if (take && !igen) begin
                        state_d = IFG;
                        cnt_d   = is_nibble(spd_q) ? IFG_NIB : IFG_GIG;
                    end
                end
                IFG: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // the phase only runs once a frame byte has been taken at 10/100M
        phase_d = 1'b0;
        if (act_ok && is_nibble(spd_d)) begin
            case (state_q)
                IDLE:    phase_d = take && igen;
                FRAME:   phase_d = ~phase_q;
                IFG:     phase_d = (cnt_q == '0) ? 1'b0 : ~phase_q;
                default: phase_d = 1'b0;
            endcase
        end
    end

    // outputs: take strobe and staging register
    always_comb begin
        igrdy_d = act_ok && (state_d != IFG) && (spd_d != MRESERVE) &&
                  (!is_nibble(spd_d) || !phase_d);

        stg_dat_d = stg_dat_q;
        stg_en_d  = stg_en_q;
        stg_er_d  = stg_er_q;

        if (!act_ok) begin
            stg_dat_d = '0;
            stg_en_d  = 1'b0;
            stg_er_d  = 1'b0;
        end else if (take) begin
            // the frame-end byte (igen=0) is consumed but never transmitted
            stg_dat_d = xmit ? igdat : '0;
            stg_en_d  = xmit;
            stg_er_d  = xmit && iger;
        end else if (!phase_q) begin
            stg_dat_d = '0;
            stg_en_d  = 1'b0;
            stg_er_d  = 1'b0;
        end
    end

    // phase=1 is the first cycle after a take, so the low nibble goes out first
    ipsmacge_txenc #(
        .DAT_DW (DAT_DW)
    ) u_txenc (
        .clk    (txclk),
        .rst    (txrst),
        .clr    (!act_ok),
        .gmii   (gmii_q),
        .spd    (spd_q),
        .nib_hi (!phase_q),
        .dat    (stg_dat_q),
        .en     (stg_en_q),
        .er     (stg_er_q),
        .hdat   (txhdat),
        .ldat   (txldat),
        .hctl   (txhctl),
        .lctl   (txlctl),
        .err    (txerr)
    );

    assign igrdy = igrdy_q;

endmodule

// File: tb/tb_ipsmacge_txintf.sv
// tb/tb_ipsmacge_txintf.sv - scoreboard testbench for ipsmacge_txintf
module tb_ipsmacge_txintf;

    logic       txclk = 1'b0;
    logic       txrst;
    logic [7:0] igdat;
    logic       igen;
    logic       iger;
    logic       igrdy;
    logic [7:0] txhdat;
    logic [7:0] txldat;
    logic       txhctl;
    logic       txlctl;
    logic       txerr;
    logic       up_act;
    logic       up_gmii;
    logic [1:0] up_mspd;

    always #5 txclk = ~txclk;

    ipsmacge_txintf #(
        .DAT_DW (8),
        .MSP_DW (2),
        .IFG_BT (12),
        .CNT_W  (9)
    ) dut (
        .txclk   (txclk),
        .txrst   (txrst),
        .igdat   (igdat),
        .igen    (igen),
        .iger    (iger),
        .igrdy   (igrdy),
        .txhdat  (txhdat),
        .txldat  (txldat),
        .txhctl  (txhctl),
        .txlctl  (txlctl),
        .txerr   (txerr),
        .up_act  (up_act),
        .up_gmii (up_gmii),
        .up_mspd (up_mspd)
    );

    typedef struct {
        logic [7:0] h;
        logic [7:0] l;
        logic       hc;
        logic       lc;
        logic       er;
        int         c;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge txclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every cycle with TX_EN high must match the next expected pin set
    always @(negedge txclk) begin
        if (txhctl === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got hdat=0x%0h ldat=0x%0h expected no output (cycle %0d)",
                         txhdat, txldat, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_hdat", txhdat, e.h);
                chk("sb_ldat", txldat, e.l);
                chk("sb_hctl", txhctl, e.hc);
                chk("sb_lctl", txlctl, e.lc);
                chk("sb_err", txerr, e.er);
                chk("sb_cycle", cyc, e.c);
            end
        end
    end

    task automatic push_ent(input logic [7:0] h, input logic [7:0] l, input logic hc,
                            input logic lc, input logic er, input int c);
        exp_t e;
        e.h = h; e.l = l; e.hc = hc; e.lc = lc; e.er = er; e.c = c;
        sbq.push_back(e);
    endtask

    // expected pins for one byte taken at cycle c
    task automatic push_byte(input logic [7:0] b, input logic er, input logic gm,
                             input logic [1:0] sp, input int c);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = {4'h0, b[3:0]};
        hi = {4'h0, b[7:4]};
        if (sp == 2'b10) begin
            if (gm) push_ent(b, b, 1'b1, 1'b1, er, c + 2);
            else    push_ent(lo, hi, 1'b1, ~er, 1'b0, c + 2);
        end else begin
            if (gm) begin
                push_ent(lo, lo, 1'b1, 1'b1, er, c + 2);
                push_ent(hi, hi, 1'b1, 1'b1, er, c + 3);
            end else begin
                push_ent(lo, lo, 1'b1, ~er, 1'b0, c + 2);
                push_ent(hi, hi, 1'b1, ~er, 1'b0, c + 3);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge txclk);
        #1;
    endtask

    // drive one frame plus its igen=0 end byte, then measure the IFG on igrdy
    task automatic send_frame(input logic [7:0] d[$], input logic e[$], input logic gm,
                              input logic [1:0] sp, input int exp_ifg);
        int n;
        int idx;
        int wc;
        int last_take;
        n = d.size();
        idx = 0;
        last_take = 0;
        igdat = d[0];
        iger  = e[0];
        igen  = 1'b1;
        while (idx <= n) begin
            wc = 0;
            @(negedge txclk);
            if (idx > 0 && sp != 2'b10) chk("igrdy_alt", igrdy, 1'b0);
            while (igrdy !== 1'b1 && wc < 100) begin
                wc++;
                @(negedge txclk);
            end
            if (wc >= 100) begin
                n_cmp++;
                n_bad++;
                $display("FAIL take_timeout: got no igrdy expected igrdy=1 within 100 cycles");
                igen = 1'b0;
                return;
            end
            if (idx > 0) chk("take_gap", cyc - last_take, (sp == 2'b10) ? 1 : 2);
            last_take = cyc;
            if (idx < n) push_byte(d[idx], e[idx], gm, sp, cyc);
            @(posedge txclk);
            #1;
            idx++;
            if (idx < n) begin
                igdat = d[idx];
                iger  = e[idx];
                igen  = 1'b1;
            end else begin
                igdat = 8'h00;
                iger  = 1'b0;
                igen  = 1'b0;
            end
        end
        wc = 0;
        @(negedge txclk);
        while (igrdy !== 1'b1 && wc < 300) begin
            wc++;
            @(negedge txclk);
        end
        chk("ifg_len", wc, exp_ifg);
    endtask

    task automatic check_idle_pins(input string tag);
        chk({tag, "_hdat"}, txhdat, 8'h00);
        chk({tag, "_ldat"}, txldat, 8'h00);
        chk({tag, "_hctl"}, txhctl, 1'b0);
        chk({tag, "_lctl"}, txlctl, 1'b0);
        chk({tag, "_err"},  txerr,  1'b0);
        chk({tag, "_igrdy"}, igrdy, 1'b0);
    endtask

    // GMII 1000M frame cut short by up_act=0 or txrst=1 while byte 3 is presented
    task automatic abort_test(input logic use_rst);
        int wc;
        wc = 0;
        igdat = 8'hB1;
        iger  = 1'b0;
        igen  = 1'b1;
        @(negedge txclk);
        while (igrdy !== 1'b1 && wc < 100) begin
            wc++;
            @(negedge txclk);
        end
        chk("abort_start", (wc < 100), 1'b1);
        push_byte(8'hB1, 1'b0, 1'b1, 2'b10, cyc);
        @(posedge txclk);
        #1;
        igdat = 8'hB2;
        @(negedge txclk);
        chk("abort_rdy", igrdy, 1'b1);
        @(posedge txclk);
        #1;
        igdat = 8'hB3;
        if (use_rst) txrst = 1'b1;
        else         up_act = 1'b0;
        @(negedge txclk);
        @(negedge txclk);
        check_idle_pins(use_rst ? "rst_abort" : "act_abort");
        txrst  = 1'b0;
        up_act = 1'b1;
        igen   = 1'b0;
        igdat  = 8'h00;
        idle(3);
    endtask

    logic [7:0] dq[$];
    logic       eq[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within 200000 time units");
        $fatal(1);
    end

    initial begin
        txrst   = 1'b1;
        igdat   = 8'h00;
        igen    = 1'b0;
        iger    = 1'b0;
        up_act  = 1'b0;
        up_gmii = 1'b0;
        up_mspd = 2'b00;
        repeat (3) @(posedge txclk);
        @(negedge txclk);
        check_idle_pins("reset");
        @(posedge txclk);
        #1;
        txrst = 1'b0;

        // GMII 1000M preamble + SFD + data
        up_act  = 1'b1;
        up_gmii = 1'b1;
        up_mspd = 2'b10;
        idle(3);
        dq = '{8'h55, 8'h55, 8'hD5, 8'hA1};
        eq = '{1'b0, 1'b0, 1'b0, 1'b0};
        send_frame(dq, eq, 1'b1, 2'b10, 12);

        // RGMII 1000M with error
        up_gmii = 1'b0;
        idle(3);
        dq = '{8'hA5};
        eq = '{1'b1};
        send_frame(dq, eq, 1'b0, 2'b10, 12);

        // MII 100M
        up_gmii = 1'b1;
        up_mspd = 2'b01;
        idle(3);
        dq = '{8'h3C, 8'h7E};
        eq = '{1'b0, 1'b0};
        send_frame(dq, eq, 1'b1, 2'b01, 24);

        // RGMII 10M
        up_gmii = 1'b0;
        up_mspd = 2'b00;
        idle(3);
        dq = '{8'h5D};
        eq = '{1'b0};
        send_frame(dq, eq, 1'b0, 2'b00, 24);

        // GMII 1000M, speed changed to 100M mid-frame; one errored byte
        up_gmii = 1'b1;
        up_mspd = 2'b10;
        idle(3);
        dq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        eq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        fork
            send_frame(dq, eq, 1'b1, 2'b10, 12);
            begin
                repeat (3) @(posedge txclk);
                #2;
                up_mspd = 2'b01;
            end
        join
        idle(3);
        dq = '{8'h9A};
        eq = '{1'b0};
        send_frame(dq, eq, 1'b1, 2'b01, 24);

        // truncation by disable and by reset
        up_mspd = 2'b10;
        idle(3);
        abort_test(1'b0);
        abort_test(1'b1);

        idle(5);
        chk("sb_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
